// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and bit-timing helpers.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package uart_pkg;

  // Frame phases shared by the receiver and transmitter state machines
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Width of the bit timer; comfortably covers any practical clock/baud ratio
  localparam int TIMER_W = 16;

  // Clocks per serial bit (integer division; caller guarantees a result >= 2)
  function automatic int calc_bit_period(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Clocks from the start-bit edge to the middle of the start bit
  function automatic int calc_half(input int clock_freq, input int baud_rate);
    return calc_bit_period(clock_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable down-counting bit timer; tick is high in the last cycle before reaching zero.
// Latency: a load of N produces tick N cycles later (acted on at that clock edge).
// Backpressure: none; a load always wins over the running count.
module uart_baud_tick #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);

  logic [W-1:0] count;

  // Expiry: the count is about to step from 1 to 0 on this edge
  assign tick = (count == W'(1));

  // Reload on request, otherwise count down and park at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start/data/optional even parity/stop, mid-bit sampling; UART_RX_SYNC_EN adds a 2-flop rx synchronizer.
// Latency: word is presented one cycle after the stop-bit sample (plus 1 or 2 cycles of rx input registering).
// Backpressure: valid/ready; a new word overwrites an unaccepted one and raises overrun_err.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int UART_DATA_WIDTH = 8,
  parameter int BAUD_RATE       = 30,
  parameter int CLOCK_FREQ      = 90,
  parameter int PARITY_BIT      = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx,
  output logic [UART_DATA_WIDTH-1:0] data,
  output logic                       valid,
  input  logic                       ready,
  output logic                       parity_err,
  output logic                       frame_err,
  output logic                       overrun_err
);

  localparam logic [TIMER_W-1:0] BIT_T  = TIMER_W'(calc_bit_period(CLOCK_FREQ, BAUD_RATE));
  localparam logic [TIMER_W-1:0] HALF_T = TIMER_W'(calc_half(CLOCK_FREQ, BAUD_RATE));
  localparam int IDX_W = (UART_DATA_WIDTH > 1) ? $clog2(UART_DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_WIDTH - 1);

  uart_state_t                state, state_nxt;
  logic                       rx_s, rx_prev;
  logic                       tick, tmr_load;
  logic [TIMER_W-1:0]         tmr_val;
  logic                       shift_en, par_en, stop_en, idx_clr;
  logic [IDX_W-1:0]           bit_idx;
  logic [UART_DATA_WIDTH-1:0] shift_data;
  logic                       par_cand, stop_cand, done;
  logic                       accept;

`ifdef UART_RX_SYNC_EN
  logic sync1, sync2;

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
    end
  end

  assign rx_s = sync2;
`else
  logic rx_q;

  // Single input register of the serial line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_q <= 1'b1;
    end else begin
      rx_q <= rx;
    end
  end

  assign rx_s = rx_q;
`endif

  // Previous sampled line level, for falling-edge detection in IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_prev <= 1'b1;
    end else begin
      rx_prev <= rx_s;
    end
  end

  uart_baud_tick #(.W(TIMER_W)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tick)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-cycle sampling controls
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = BIT_T;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    stop_en   = 1'b0;
    idx_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          state_nxt = START;
          tmr_load  = 1'b1;
          tmr_val   = HALF_T;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s) begin
            state_nxt = DATA;
            tmr_load  = 1'b1;
            idx_clr   = 1'b1;
          end else begin
            // Line went back high before mid-start: treat as a glitch
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          tmr_load = 1'b1;
          if (bit_idx == LAST_IDX) begin
            state_nxt = (PARITY_BIT != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          par_en    = 1'b1;
          tmr_load  = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          stop_en   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame assembly: LSB-first shift register, bit index, error candidates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_idx    <= '0;
      shift_data <= '0;
      par_cand   <= 1'b0;
      stop_cand  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= stop_en;
      if (idx_clr) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + IDX_W'(1);
      end
      if (shift_en) begin
        shift_data <= {rx_s, shift_data[UART_DATA_WIDTH-1:1]};
      end
      if (par_en) begin
        par_cand <= (^shift_data) ^ rx_s;
      end
      if (stop_en) begin
        stop_cand <= ~rx_s;
      end
    end
  end

  assign accept = valid && ready;

  // Output word register with valid/ready handshake and overrun tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data        <= '0;
      valid       <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (done) begin
        data       <= shift_data;
        parity_err <= (PARITY_BIT != 0) ? par_cand : 1'b0;
        frame_err  <= stop_cand;
        valid      <= 1'b1;
      end else if (accept) begin
        valid <= 1'b0;
      end
      if (done && valid && !ready) begin
        overrun_err <= 1'b1;
      end else if (accept) begin
        overrun_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit with even parity.
// Table-driven frames plus hand-written glitch, overrun and mid-frame reset sequences.
// Consumer ready is held low until each word is checked, then pulsed for one cycle.
module tb_uart_receiver;

  localparam int BP = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] byte_in;
    logic       par_in;
    logic       stop_in;
    logic [7:0] exp_data;
    logic       exp_par;
    logic       exp_frame;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  uart_receiver #(
    .UART_DATA_WIDTH (8),
    .BAUD_RATE       (10),
    .CLOCK_FREQ      (160),
    .PARITY_BIT      (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive rx to a level for n clock cycles; returns #1 after a rising edge
  task automatic hold(input logic b, input int n);
    rx = b;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    hold(1'b0, BP);
    for (int i = 0; i < 8; i++) hold(d[i], BP);
    hold(p, BP);
    hold(s, BP);
    rx = 1'b1;
  endtask

  // Bounded wait for valid; an expired budget shows up as a failed check
  task automatic wait_valid(input string name);
    for (int i = 0; i < 64 && valid !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    check(name, 32'(valid), 32'd1);
  endtask

  task automatic accept_word(input string name);
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    check({name, " valid after accept"}, 32'(valid), 32'd0);
    check({name, " overrun after accept"}, 32'(overrun_err), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[7] = '{8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1};

    reset = 1'b1;
    rx    = 1'b1;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset data", 32'(data), 32'h0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset parity_err", 32'(parity_err), 32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    check("reset overrun_err", 32'(overrun_err), 32'd0);
    reset = 1'b0;
    hold(1'b1, 10);

    // Short low pulse must be rejected at the mid-start check
    hold(1'b0, 5);
    hold(1'b1, 3 * BP);
    check("glitch valid", 32'(valid), 32'd0);

    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].byte_in, vecs[v].par_in, vecs[v].stop_in);
      hold(1'b1, 4);
      wait_valid($sformatf("vec%0d valid", v));
      check($sformatf("vec%0d data", v), 32'(data), 32'(vecs[v].exp_data));
      check($sformatf("vec%0d parity_err", v), 32'(parity_err), 32'(vecs[v].exp_par));
      check($sformatf("vec%0d frame_err", v), 32'(frame_err), 32'(vecs[v].exp_frame));
      check($sformatf("vec%0d overrun_err", v), 32'(overrun_err), 32'd0);
      hold(1'b1, 5);
      check($sformatf("vec%0d data stable", v), 32'(data), 32'(vecs[v].exp_data));
      accept_word($sformatf("vec%0d", v));
      hold(1'b1, 6);
    end

    // Back-to-back frames with no idle gap while the consumer stalls
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    hold(1'b1, 4);
    wait_valid("b2b valid");
    check("b2b data", 32'(data), 32'h22);
    check("b2b overrun_err", 32'(overrun_err), 32'd1);
    check("b2b parity_err", 32'(parity_err), 32'd0);
    check("b2b frame_err", 32'(frame_err), 32'd0);
    accept_word("b2b");
    hold(1'b1, 6);

    // Reset in the middle of data bit 3, then a clean frame
    hold(1'b0, BP);
    hold(1'b0, BP);
    hold(1'b0, BP);
    hold(1'b0, BP);
    hold(1'b1, BP / 2);
    reset = 1'b1;
    #1;
    check("midreset valid during reset", 32'(valid), 32'd0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    hold(1'b1, 3 * BP);
    check("midreset valid after release", 32'(valid), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1);
    hold(1'b1, 4);
    wait_valid("midreset frame valid");
    check("midreset data", 32'(data), 32'h5A);
    check("midreset parity_err", 32'(parity_err), 32'd0);
    check("midreset frame_err", 32'(frame_err), 32'd0);
    check("midreset overrun_err", 32'(overrun_err), 32'd0);
    accept_word("midreset");
    hold(1'b1, 3 * BP);
    check("midreset no extra word", 32'(valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
